// File: rtl/four_phase_rx_fifo.sv
// RX-side endpoint of a four-phase req/ack clock-domain crossing.
// Each synchronised request is queued in an elastic FIFO that drains as a valid/ready stream.
module four_phase_rx_fifo #(
   parameter int unsigned DW          = 32,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_n,
   input  logic                         req_i,
   input  logic [DW-1:0]                req_data_i,
   output logic                         ack_o,
   output logic                         m_valid_o,
   output logic [DW-1:0]                m_data_o,
   input  logic                         m_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   level_o,
   output logic                         stall_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_SPACE = 2'd1,
      ACKED      = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   ack_q, ack_d;
   logic                   stall_q, stall_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   logic [DW-1:0]          mem [DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]          level_q;
   logic                   push_c, pop_c, space_c;

   // Request synchroniser; only the last stage is used by the FSM
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
   end

   assign req_s   = sync_q[SYNC_STAGES-1];
   assign pop_c   = m_valid_o & m_ready_i;
   // A pop frees a slot on the same edge, so a full FIFO can still accept a capture
   assign space_c = (level_q < LW'(DEPTH)) | pop_c;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         stall_q <= stall_d;
      end
   end

   // Handshake FSM: one capture per request, ack withheld while the FIFO is full
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      stall_d = 1'b0;
      push_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_s) begin
               if (space_c) begin
                  push_c  = 1'b1;
                  ack_d   = 1'b1;
                  state_d = ACKED;
               end else begin
                  stall_d = 1'b1;
                  state_d = WAIT_SPACE;
               end
            end
         end
         WAIT_SPACE: begin
            stall_d = 1'b1;
            if (space_c) begin
               push_c  = 1'b1;
               ack_d   = 1'b1;
               stall_d = 1'b0;
               state_d = ACKED;
            end
         end
         ACKED: begin
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            ack_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push_c) mem[wr_ptr_q] <= req_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_c && !pop_c)      level_q <= level_q + LW'(1);
         else if (pop_c && !push_c) level_q <= level_q - LW'(1);
      end
   end

   assign ack_o     = ack_q;
   assign stall_o   = stall_q;
   assign level_o   = level_q;
   assign m_valid_o = (level_q != '0);
   assign m_data_o  = m_valid_o ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_four_phase_rx_fifo.sv
// Directed bench for four_phase_rx_fifo (DW=32, DEPTH=4, SYNC_STAGES=2).
module tb_four_phase_rx_fifo;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic        req_i;
   logic [31:0] req_data_i;
   logic        ack_o;
   logic        m_valid_o;
   logic [31:0] m_data_o;
   logic        m_ready_i;
   logic [2:0]  level_o;
   logic        stall_o;

   int          n_assert = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   bit          rand_en  = 1'b0;
   logic [31:0] exp_next;

   four_phase_rx_fifo #(.DW(32), .DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk_i      (clk_i),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .req_data_i (req_data_i),
      .ack_o      (ack_o),
      .m_valid_o  (m_valid_o),
      .m_data_o   (m_data_o),
      .m_ready_i  (m_ready_i),
      .level_o    (level_o),
      .stall_o    (stall_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ack"},   64'(ack_o),     64'd0);
      chk({tag, "_valid"}, 64'(m_valid_o), 64'd0);
      chk({tag, "_data"},  64'(m_data_o),  64'd0);
      chk({tag, "_level"}, 64'(level_o),   64'd0);
      chk({tag, "_stall"}, 64'(stall_o),   64'd0);
   endtask

   // One rising edge; results are sampled on the following falling edge
   task automatic tick();
      if (mon_en) begin
         if (m_valid_o && m_ready_i) begin
            chk("wrap_order", 64'(m_data_o), 64'(exp_next));
            exp_next = exp_next + 32'd1;
         end
         chk("wrap_level_bound", 64'(level_o <= 3'd4), 64'd1);
      end
      @(posedge clk_i);
      @(negedge clk_i);
      if (rand_en) m_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic handshake(input logic [31:0] d);
      int n;
      req_data_i = d;
      req_i      = 1'b1;
      n = 0;
      while (ack_o !== 1'b1 && n < 60) begin tick(); n++; end
      chk("hs_ack_rise", 64'(ack_o), 64'd1);
      req_i = 1'b0;
      n = 0;
      while (ack_o !== 1'b0 && n < 60) begin tick(); n++; end
      chk("hs_ack_fall", 64'(ack_o), 64'd0);
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      req_i      = 1'b0;
      req_data_i = 32'h0;
      m_ready_i  = 1'b0;

      // Reset held while req toggles
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         req_i = ~req_i;
      end
      req_i = 1'b0;
      @(negedge clk_i);
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk_idle_outputs("post_reset_idle");

      // Single transfer with latency checks
      req_data_i = 32'hDEADBEEF;
      req_i      = 1'b1;
      tick(); tick();
      chk("single_ack_edge2", 64'(ack_o), 64'd0);
      tick();
      chk("single_ack_edge3",   64'(ack_o),     64'd1);
      chk("single_valid_edge3", 64'(m_valid_o), 64'd1);
      chk("single_data_edge3",  64'(m_data_o),  64'hDEADBEEF);
      chk("single_level",       64'(level_o),   64'd1);
      req_i = 1'b0;
      tick(); tick();
      chk("single_ack_hold", 64'(ack_o), 64'd1);
      tick();
      chk("single_ack_fall",    64'(ack_o),   64'd0);
      chk("single_level_after", 64'(level_o), 64'd1);
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      chk("single_pop_valid", 64'(m_valid_o), 64'd0);
      chk("single_pop_level", 64'(level_o),   64'd0);

      // Burst fill then stall
      for (int i = 1; i <= 4; i++) handshake(32'(i));
      chk("burst_level_full", 64'(level_o),  64'd4);
      chk("burst_head",       64'(m_data_o), 64'd1);
      req_data_i = 32'd5;
      req_i      = 1'b1;
      tick(); tick();
      chk("burst_stall_early", 64'(stall_o), 64'd0);
      tick();
      chk("burst_stall_rise", 64'(stall_o), 64'd1);
      chk("burst_ack_held",   64'(ack_o),   64'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("burst_stall_hold", 64'(stall_o),  64'd1);
      chk("burst_ack_hold",   64'(ack_o),    64'd0);
      chk("burst_head_hold",  64'(m_data_o), 64'd1);
      chk("burst_level_hold", 64'(level_o),  64'd4);
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      chk("burst_ack_on_pop",   64'(ack_o),    64'd1);
      chk("burst_stall_fall",   64'(stall_o),  64'd0);
      chk("burst_level_same",   64'(level_o),  64'd4);
      chk("burst_head_next",    64'(m_data_o), 64'd2);
      req_i = 1'b0;
      n = 0;
      while (ack_o !== 1'b0 && n < 20) begin tick(); n++; end
      chk("burst_ack_fall", 64'(ack_o), 64'd0);

      // Drain in order
      m_ready_i = 1'b1;
      chk("drain_2", 64'(m_data_o), 64'd2);
      tick();
      chk("drain_3", 64'(m_data_o), 64'd3);
      tick();
      chk("drain_4", 64'(m_data_o), 64'd4);
      tick();
      chk("drain_5", 64'(m_data_o), 64'd5);
      tick();
      m_ready_i = 1'b0;
      chk_idle_outputs("drain_empty");

      // Wrap with random consumer backpressure
      exp_next  = 32'd100;
      mon_en    = 1'b1;
      rand_en   = 1'b1;
      m_ready_i = 1'b1;
      for (int i = 0; i < 13; i++) handshake(32'd100 + 32'(i));
      rand_en   = 1'b0;
      m_ready_i = 1'b1;
      n = 0;
      while (m_valid_o && n < 30) begin tick(); n++; end
      mon_en    = 1'b0;
      m_ready_i = 1'b0;
      chk("wrap_count", 64'(exp_next), 64'd113);
      chk("wrap_empty", 64'(level_o),  64'd0);

      // Reset while in ACKED with two words queued
      handshake(32'hA0A0_0001);
      req_data_i = 32'hB0B0_0002;
      req_i      = 1'b1;
      n = 0;
      while (ack_o !== 1'b1 && n < 20) begin tick(); n++; end
      chk("midrst_acked", 64'(ack_o),   64'd1);
      chk("midrst_level", 64'(level_o), 64'd2);
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("midrst_async");
      @(negedge clk_i);
      rst_n = 1'b1;
      tick(); tick();
      chk("midrst_ack_edge2", 64'(ack_o), 64'd0);
      tick();
      chk("midrst_ack_edge3", 64'(ack_o),    64'd1);
      chk("midrst_level_1",   64'(level_o),  64'd1);
      chk("midrst_data",      64'(m_data_o), 64'hB0B0_0002);
      req_i = 1'b0;
      n = 0;
      while (ack_o !== 1'b0 && n < 20) begin tick(); n++; end
      chk("midrst_ack_fall",   64'(ack_o),   64'd0);
      chk("midrst_level_keep", 64'(level_o), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
